// File: rtl/sfx_apu.sv
// Multi-channel one-shot sound-effect generator: per-channel square/saw/noise
// voices with a linear release envelope, a priority or saturating mixer and a PWM pin.
module sfx_apu #(
    parameter int NUM_CH      = 3,
    parameter int PERIOD_BITS = 16,
    parameter int DUR_BITS    = 12,
    parameter int MIX_MODE    = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CH-1:0]             trig,
    input  logic                          env_tick,
    input  logic [NUM_CH*PERIOD_BITS-1:0] period,
    input  logic [NUM_CH*2-1:0]           mode,
    input  logic [NUM_CH*DUR_BITS-1:0]    duration,
    output logic [NUM_CH-1:0]             active,
    output logic [7:0]                    sample,
    output logic                          sound
);

    typedef enum logic {
        IDLE    = 1'b0,
        PLAYING = 1'b1
    } ch_state_e;

    logic [7:0] level_arr [NUM_CH];
    logic [7:0] mix_next;
    logic [7:0] sample_reg;
    logic [7:0] pwm_cnt_reg;
    logic       sound_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            ch_state_e               state_reg, state_next;
            logic [DUR_BITS-1:0]     dur_reg, dur_next;
            logic [PERIOD_BITS-1:0]  phase_reg, phase_next;
            logic                    square_reg, square_next;
            logic [7:0]              ramp_reg, ramp_next;
            logic [7:0]              lfsr_reg, lfsr_next;
            logic [PERIOD_BITS-1:0]  ch_period;
            logic [1:0]              ch_mode;
            logic [DUR_BITS-1:0]     ch_dur;
            logic                    wrap;
            logic [7:0]              raw;
            logic [3:0]              vol;
            logic [7:0]              level;

            assign ch_period = period[gi*PERIOD_BITS +: PERIOD_BITS];
            assign ch_mode   = mode[gi*2 +: 2];
            assign ch_dur    = duration[gi*DUR_BITS +: DUR_BITS];

            always_ff @(posedge clk) begin
                if (reset) begin
                    state_reg  <= IDLE;
                    dur_reg    <= '0;
                    phase_reg  <= '0;
                    square_reg <= 1'b0;
                    ramp_reg   <= 8'd0;
                    lfsr_reg   <= 8'hA5 ^ 8'(gi);
                end else begin
                    state_reg  <= state_next;
                    dur_reg    <= dur_next;
                    phase_reg  <= phase_next;
                    square_reg <= square_next;
                    ramp_reg   <= ramp_next;
                    lfsr_reg   <= lfsr_next;
                end
            end

            // Trigger has priority over the duration countdown in the same cycle.
            always_comb begin
                state_next = state_reg;
                dur_next   = dur_reg;
                if (trig[gi]) begin
                    dur_next   = ch_dur;
                    state_next = (ch_dur != '0) ? PLAYING : IDLE;
                end else if (state_reg == PLAYING && env_tick) begin
                    if (dur_reg == DUR_BITS'(1)) begin
                        dur_next   = '0;
                        state_next = IDLE;
                    end else begin
                        dur_next = dur_reg - DUR_BITS'(1);
                    end
                end
            end

            // Period 0 and 1 both wrap every clock; the LFSR keeps running across notes.
            always_comb begin
                wrap        = (ch_period == '0) || (phase_reg >= ch_period - PERIOD_BITS'(1));
                phase_next  = phase_reg;
                square_next = square_reg;
                ramp_next   = ramp_reg;
                lfsr_next   = lfsr_reg;
                if (trig[gi]) begin
                    phase_next  = '0;
                    square_next = 1'b0;
                    ramp_next   = 8'd0;
                end else if (state_reg == PLAYING) begin
                    if (wrap) begin
                        phase_next  = '0;
                        square_next = ~square_reg;
                        ramp_next   = ramp_reg + 8'd1;
                        lfsr_next   = {lfsr_reg[6:0],
                                       lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
                    end else begin
                        phase_next = phase_reg + PERIOD_BITS'(1);
                    end
                end
            end

            always_comb begin
                raw = 8'd0;
                if (state_reg == PLAYING) begin
                    case (ch_mode)
                        2'd0:    raw = square_reg ? 8'hFF : 8'h00;
                        2'd1:    raw = ramp_reg;
                        2'd2:    raw = lfsr_reg;
                        default: raw = 8'd0;
                    endcase
                end
                vol   = (dur_reg >= DUR_BITS'(15)) ? 4'd15 : dur_reg[3:0];
                level = 8'(({4'd0, raw} * {8'd0, vol}) >> 4);
            end

            assign active[gi]    = (state_reg == PLAYING);
            assign level_arr[gi] = level;
        end

        if (MIX_MODE == 0) begin : g_prio
            // Walk from the highest index down so the lowest active index wins.
            always_comb begin
                mix_next = 8'd0;
                for (int i = NUM_CH - 1; i >= 0; i--) begin
                    if (active[i]) begin
                        mix_next = level_arr[i];
                    end
                end
            end
        end else begin : g_sum
            logic [10:0] sum;
            always_comb begin
                sum = 11'd0;
                for (int i = 0; i < NUM_CH; i++) begin
                    sum = sum + {3'd0, level_arr[i]};
                end
                mix_next = (sum > 11'd255) ? 8'hFF : sum[7:0];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_reg  <= 8'd0;
            pwm_cnt_reg <= 8'd0;
            sound_reg   <= 1'b0;
        end else begin
            sample_reg  <= mix_next;
            pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
            sound_reg   <= (pwm_cnt_reg < sample_reg);
        end
    end

    assign sample = sample_reg;
    assign sound  = sound_reg;

endmodule

// File: tb/tb_sfx_apu.sv
// Bench for sfx_apu: priority and summing instances driven in parallel, checked
// against a cycle-level arithmetic model, a hand-computed vector table and corner sequences.
module tb_sfx_apu;
    localparam int NCH = 3;
    localparam int PB  = 16;
    localparam int DB  = 12;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NCH-1:0]     trig = '0;
    logic               env_tick = 1'b0;
    logic [NCH*PB-1:0]  period = '0;
    logic [NCH*2-1:0]   mode = '0;
    logic [NCH*DB-1:0]  duration = '0;
    logic [NCH-1:0]     active_p, active_s;
    logic [7:0]         sample_p, sample_s;
    logic               sound_p, sound_s;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sfx_apu #(.NUM_CH(NCH), .PERIOD_BITS(PB), .DUR_BITS(DB), .MIX_MODE(0)) u_prio (
        .clk(clk), .reset(reset), .trig(trig), .env_tick(env_tick), .period(period),
        .mode(mode), .duration(duration), .active(active_p), .sample(sample_p), .sound(sound_p));

    sfx_apu #(.NUM_CH(NCH), .PERIOD_BITS(PB), .DUR_BITS(DB), .MIX_MODE(1)) u_sum (
        .clk(clk), .reset(reset), .trig(trig), .env_tick(env_tick), .period(period),
        .mode(mode), .duration(duration), .active(active_s), .sample(sample_s), .sound(sound_s));

    // Reference model: plain integers per channel, stepped once per clock.
    int m_play [NCH];
    int m_dur  [NCH];
    int m_phase[NCH];
    int m_sq   [NCH];
    int m_ramp [NCH];
    int m_lfsr [NCH];
    int m_pwm, m_samp_p, m_samp_s, m_snd_p, m_snd_s;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int level_of(input int i);
        int raw, vol;
        if (m_play[i] == 0) return 0;
        case (int'(mode[i*2 +: 2]))
            0:       raw = m_sq[i] ? 255 : 0;
            1:       raw = m_ramp[i];
            2:       raw = m_lfsr[i];
            default: raw = 0;
        endcase
        vol = (m_dur[i] >= 15) ? 15 : m_dur[i];
        return (raw * vol) / 16;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_play[i] = 0; m_dur[i] = 0; m_phase[i] = 0;
            m_sq[i] = 0; m_ramp[i] = 0; m_lfsr[i] = 'hA5 ^ i;
        end
        m_pwm = 0; m_samp_p = 0; m_samp_s = 0; m_snd_p = 0; m_snd_s = 0;
    endtask

    task automatic model_step();
        int pick, found, sum, per, b;
        if (reset) begin
            model_reset();
            return;
        end
        pick = 0; found = 0; sum = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m_play[i] != 0 && found == 0) begin
                pick = level_of(i);
                found = 1;
            end
            sum += level_of(i);
        end
        m_snd_p  = (m_pwm < m_samp_p) ? 1 : 0;
        m_snd_s  = (m_pwm < m_samp_s) ? 1 : 0;
        m_samp_p = pick;
        m_samp_s = (sum > 255) ? 255 : sum;
        m_pwm    = (m_pwm + 1) % 256;
        for (int i = 0; i < NCH; i++) begin
            per = int'(period[i*PB +: PB]);
            if (trig[i]) begin
                m_dur[i] = int'(duration[i*DB +: DB]);
                m_phase[i] = 0; m_sq[i] = 0; m_ramp[i] = 0;
                m_play[i] = (m_dur[i] != 0) ? 1 : 0;
            end else if (m_play[i] != 0) begin
                if (m_phase[i] >= per - 1) begin
                    m_phase[i] = 0;
                    m_sq[i] = 1 - m_sq[i];
                    m_ramp[i] = (m_ramp[i] + 1) % 256;
                    b = ((m_lfsr[i] >> 7) ^ (m_lfsr[i] >> 5) ^ (m_lfsr[i] >> 4) ^ (m_lfsr[i] >> 3)) & 1;
                    m_lfsr[i] = ((m_lfsr[i] * 2) + b) % 256;
                end else begin
                    m_phase[i]++;
                end
                if (env_tick) begin
                    if (m_dur[i] == 1) begin
                        m_dur[i] = 0;
                        m_play[i] = 0;
                    end else begin
                        m_dur[i]--;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        int exp_act;
        exp_act = 0;
        for (int i = 0; i < NCH; i++) exp_act += m_play[i] << i;
        chk("active_p", int'(active_p), exp_act);
        chk("active_s", int'(active_s), exp_act);
        chk("sample_p", int'(sample_p), m_samp_p);
        chk("sample_s", int'(sample_s), m_samp_s);
        chk("sound_p", int'(sound_p), m_snd_p);
        chk("sound_s", int'(sound_s), m_snd_s);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_ch(input int i, input int per, input int md, input int dur);
        period[i*PB +: PB] = PB'(per);
        mode[i*2 +: 2]     = 2'(md);
        duration[i*DB +: DB] = DB'(dur);
    endtask

    task automatic do_reset();
        reset = 1'b1; trig = '0; env_tick = 1'b0;
        repeat (3) begin
            tick();
            chk("rst_active", int'(active_p), 0);
            chk("rst_sample", int'(sample_p), 0);
            chk("rst_sound", int'(sound_p), 0);
        end
        reset = 1'b0;
    endtask

    typedef struct {
        logic [NCH-1:0] trig;
        logic           env;
        logic [NCH-1:0] act;
        int             samp;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int maxv, ones, found;

        // Square on ch0, period 4, duration 3: hand-derived sample/active sequence.
        tbl[0]  = '{3'b001, 1'b0, 3'b001, 0};
        tbl[1]  = '{3'b000, 1'b0, 3'b001, 0};
        tbl[2]  = '{3'b000, 1'b0, 3'b001, 0};
        tbl[3]  = '{3'b000, 1'b0, 3'b001, 0};
        tbl[4]  = '{3'b000, 1'b0, 3'b001, 0};
        tbl[5]  = '{3'b000, 1'b0, 3'b001, 47};
        tbl[6]  = '{3'b000, 1'b1, 3'b001, 47};
        tbl[7]  = '{3'b000, 1'b0, 3'b001, 31};
        tbl[8]  = '{3'b000, 1'b1, 3'b001, 31};
        tbl[9]  = '{3'b000, 1'b0, 3'b001, 0};
        tbl[10] = '{3'b000, 1'b1, 3'b000, 0};
        tbl[11] = '{3'b000, 1'b0, 3'b000, 0};

        model_reset();
        do_reset();

        // Channel 1 noise right after reset exposes its seed A4: 164*15>>4 = 153.
        set_ch(1, 1000, 2, 20);
        trig = 3'b010; tick();
        trig = 3'b000; tick();
        chk("lfsr_seed_ch1", int'(sample_p), 153);
        $display("seed check: sample_p=%0d", sample_p);

        do_reset();
        set_ch(0, 4, 0, 3); set_ch(1, 4, 3, 0); set_ch(2, 4, 3, 0);
        for (int r = 0; r < 12; r++) begin
            trig = tbl[r].trig; env_tick = tbl[r].env;
            tick();
            chk("tbl_active_p", int'(active_p), int'(tbl[r].act));
            chk("tbl_sample_p", int'(sample_p), tbl[r].samp);
            chk("tbl_sample_s", int'(sample_s), tbl[r].samp);
            $display("vec %0d: trig=%b env=%b active=%b sample=%0d", r, tbl[r].trig, tbl[r].env, active_p, sample_p);
        end
        trig = '0; env_tick = 1'b0;

        // Envelope fade: full volume through 5 ticks, 255*14>>4 = 223 after 6.
        do_reset();
        set_ch(0, 4, 0, 20);
        trig = 3'b001; tick(); trig = '0;
        for (int k = 1; k <= 20; k++) begin
            env_tick = 1'b1; tick(); env_tick = 1'b0;
            if (k == 19) chk("env_active_19", int'(active_p[0]), 1);
            if (k == 20) chk("env_active_20", int'(active_p[0]), 0);
            maxv = 0;
            for (int c = 0; c < 9; c++) begin
                tick();
                if (int'(sample_p) > maxv) maxv = int'(sample_p);
            end
            if (k == 5) chk("peak_after_5", maxv, 239);
            if (k == 6) chk("peak_after_6", maxv, 223);
            $display("env tick %0d: active=%b peak=%0d", k, active_p, maxv);
        end

        // Priority handover: ch0 square over ch2 noise until ch0 expires.
        do_reset();
        set_ch(0, 3, 0, 4); set_ch(2, 2, 2, 40);
        trig = 3'b101; tick(); trig = '0;
        for (int c = 0; c < 60; c++) begin
            env_tick = (c % 6 == 5); tick();
        end
        env_tick = 1'b0;
        chk("handover_active", int'(active_p), 3'b100);
        $display("handover: active=%b sample_p=%0d", active_p, sample_p);

        // Saturating sum of two full-volume squares in phase.
        do_reset();
        set_ch(0, 4, 0, 30); set_ch(1, 4, 0, 30); set_ch(2, 4, 3, 0);
        trig = 3'b011; tick(); trig = '0;
        maxv = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (int'(sample_s) > maxv) maxv = int'(sample_s);
        end
        chk("sum_saturate", maxv, 255);
        $display("sum mix: peak sample_s=%0d", maxv);

        // Retrigger coinciding with env_tick at dur=3 reloads without decrementing.
        do_reset();
        set_ch(1, 5, 0, 5);
        trig = 3'b010; tick(); trig = '0;
        env_tick = 1'b1; tick(); tick();
        trig = 3'b010; tick(); trig = '0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 4) chk("retrig_active_4", int'(active_p[1]), 1);
            if (k == 5) chk("retrig_active_5", int'(active_p[1]), 0);
        end
        env_tick = 1'b0;
        $display("retrigger: active=%b", active_p);

        // Zero duration never starts the voice.
        do_reset();
        set_ch(0, 4, 0, 0);
        trig = 3'b001; tick(); trig = '0;
        for (int c = 0; c < 6; c++) tick();
        chk("dur0_active", int'(active_p), 0);
        chk("dur0_sample", int'(sample_p), 0);
        $display("zero duration: active=%b sample=%0d", active_p, sample_p);

        // Hold saw at ramp 137 (137*15>>4 = 128) and measure one PWM frame.
        set_ch(0, 1, 1, 4095);
        trig = 3'b001; tick(); trig = '0;
        found = 0;
        for (int c = 0; c < 400 && found == 0; c++) begin
            if (m_ramp[0] == 137) found = 1;
            else tick();
        end
        chk("ramp_reached", found, 1);
        set_ch(0, 65535, 1, 4095);
        repeat (3) tick();
        chk("duty_sample", int'(sample_p), 128);
        ones = 0;
        for (int c = 0; c < 256; c++) begin
            tick();
            ones += int'(sound_p);
        end
        chk("duty_128", ones, 128);
        $display("pwm duty: %0d high of 256", ones);

        // Reset mid-note clears everything on the next edge.
        set_ch(1, 3, 2, 50);
        trig = 3'b010; tick(); trig = '0;
        repeat (5) tick();
        reset = 1'b1; tick();
        chk("midreset_active", int'(active_p), 0);
        chk("midreset_sample", int'(sample_p), 0);
        chk("midreset_sound", int'(sound_s), 0);
        reset = 1'b0;
        $display("mid-note reset: active=%b sample=%0d", active_p, sample_p);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(15, 0) == 0) begin
                for (int i = 0; i < NCH; i++)
                    set_ch(i, $urandom_range(12, 0), $urandom_range(3, 0), $urandom_range(25, 0));
            end
            for (int i = 0; i < NCH; i++) trig[i] = ($urandom_range(39, 0) == 0);
            env_tick = ($urandom_range(7, 0) == 0);
            reset = ($urandom_range(999, 0) == 0);
            tick();
            if (c % 1000 == 999) $display("random batch to cycle %0d: active=%b sample_p=%0d", c + 1, active_p, sample_p);
        end
        reset = 1'b0; trig = '0; env_tick = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
